// File: rtl/max_stream.sv
// max_stream: windowed maximum finder over a multi-lane input stream.
// Each accepted beat is reduced to its largest lane (Stage A). The beat
// maxima are then folded into a running maximum across WIN beats (Stage B).
// The window winner is presented on a valid/ready output register.
//
// Handshake semantics: a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds data stable while valid
// is high and ready is low. in_ready drops on the edge that accepts the last
// beat of a window. It rises again on the edge that completes the output
// handshake, so at most one window result is ever in flight.
module max_stream #(
  parameter int WIDTH    = 8,
  parameter int LANES    = 4,
  parameter int WIN      = 4,
  parameter int SIGNED   = 0,
  parameter int DROP_LSB = 0,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int BW = (WIN > 1) ? $clog2(WIN) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_max,
  output logic [LW-1:0]          out_lane,
  output logic [BW-1:0]          out_beat
);

  localparam int KW = WIDTH - DROP_LSB;

  // Strict greater-than on the compare field [WIDTH-1:DROP_LSB].
  // For signed mode, flipping the field MSB maps two's complement order onto
  // unsigned order. Strictness means ties keep the incumbent.
  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [KW-1:0] ka;
    logic [KW-1:0] kb;
    ka = a[WIDTH-1:DROP_LSB];
    kb = b[WIDTH-1:DROP_LSB];
    if (SIGNED != 0) begin
      ka[KW-1] = ~ka[KW-1];
      kb[KW-1] = ~kb[KW-1];
    end
    return ka > kb;
  endfunction

  logic             accept;
  logic             last_beat;
  logic [BW-1:0]    cnt;
  logic [WIDTH-1:0] bm;
  logic [LW-1:0]    bl;

  logic             a_valid;
  logic             a_last;
  logic [WIDTH-1:0] a_max;
  logic [LW-1:0]    a_lane;
  logic [BW-1:0]    a_beat;

  logic             b_done;
  logic [WIDTH-1:0] r_max;
  logic [LW-1:0]    r_lane;
  logic [BW-1:0]    r_beat;

  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == BW'(WIN - 1));

  // Lane reduction of the offered beat; scanning upward with a strict
  // compare leaves the lowest lane on ties.
  always_comb begin
    bm = in_data[WIDTH-1:0];
    bl = '0;
    for (int k = 1; k < LANES; k++) begin
      if (gt(in_data[k*WIDTH +: WIDTH], bm)) begin
        bm = in_data[k*WIDTH +: WIDTH];
        bl = LW'(k);
      end
    end
  end

  // Stage A: capture the beat maximum, the beat counter and the input gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid  <= 1'b0;
      a_last   <= 1'b0;
      a_max    <= '0;
      a_lane   <= '0;
      a_beat   <= '0;
      cnt      <= '0;
      in_ready <= 1'b1;
    end else begin
      a_valid <= accept;
      if (accept) begin
        a_max  <= bm;
        a_lane <= bl;
        a_beat <= cnt;
        a_last <= last_beat;
        if (last_beat) begin
          cnt      <= '0;
          in_ready <= 1'b0;
        end else begin
          cnt <= cnt + BW'(1);
        end
      end
      if (out_valid && out_ready) begin
        in_ready <= 1'b1;
      end
    end
  end

  // Stage B: fold beat maxima into the running window maximum.
  // The running state is cleared once the output register has taken it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_done <= 1'b0;
      r_max  <= '0;
      r_lane <= '0;
      r_beat <= '0;
    end else begin
      b_done <= a_valid && a_last;
      if (a_valid) begin
        if ((a_beat == '0) || gt(a_max, r_max)) begin
          r_max  <= a_max;
          r_lane <= a_lane;
          r_beat <= a_beat;
        end
      end else if (b_done) begin
        r_max  <= '0;
        r_lane <= '0;
        r_beat <= '0;
      end
    end
  end

  // Output register: load the window winner and hold it until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_max   <= '0;
      out_lane  <= '0;
      out_beat  <= '0;
    end else begin
      if (b_done) begin
        out_valid <= 1'b1;
        out_max   <= r_max;
        out_lane  <= r_lane;
        out_beat  <= r_beat;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_max_stream.sv
// Testbench for max_stream. Four instances cover the following configurations:
// - defaults;
// - SIGNED=1;
// - DROP_LSB=2 with WIN=2;
// - WIN=1.
// Expected window results come from an independent integer-key model. They
// are queued when a window is driven and popped when an output handshake is seen.
module tb_max_stream;

  localparam int W = 12;
  localparam int SGN[4]  = '{0, 1, 0, 0};
  localparam int DRP[4]  = '{0, 0, 2, 0};
  localparam int WINS[4] = '{4, 4, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid[4];
  logic        in_ready[4];
  logic [31:0] in_data[4];
  logic        out_valid[4];
  logic        out_ready[4];
  logic [7:0]  out_max[4];
  logic [1:0]  out_lane[4];
  logic [1:0]  ob0, ob1;
  logic        ob2, ob3;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_out = 0;
  logic [31:0]  wb[4];

  // clock / reset
  always #5 clk = ~clk;

  max_stream u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_max(out_max[0]), .out_lane(out_lane[0]), .out_beat(ob0));
  max_stream #(.SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_max(out_max[1]), .out_lane(out_lane[1]), .out_beat(ob1));
  max_stream #(.WIN(2), .DROP_LSB(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_max(out_max[2]), .out_lane(out_lane[2]), .out_beat(ob2));
  max_stream #(.WIN(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_max(out_max[3]), .out_lane(out_lane[3]), .out_beat(ob3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] obs(input int i);
    case (i)
      0:       return {out_max[0], out_lane[0], ob0};
      1:       return {out_max[1], out_lane[1], ob1};
      2:       return {out_max[2], out_lane[2], 1'b0, ob2};
      default: return {out_max[3], out_lane[3], 1'b0, ob3};
    endcase
  endfunction

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Ordering key: value with dropped LSBs floored away, signed or unsigned.
  function automatic int key(input logic [7:0] v, input int i);
    int t;
    if (SGN[i] != 0) begin
      t = int'($signed(v));
      return t >>> DRP[i];
    end
    t = int'(v);
    return t >> DRP[i];
  endfunction

  // Reference model: the first strict maximum in beat-major, lane-minor order.
  task automatic push_window(input int i, input int nb);
    int         bk, bl, bb, kk;
    logic [7:0] bv, v;
    bk = 0; bl = 0; bb = 0; bv = 8'h00;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 4; k++) begin
        v  = wb[b][k*8 +: 8];
        kk = key(v, i);
        if ((b == 0 && k == 0) || kk > bk) begin
          bk = kk; bv = v; bl = k; bb = b;
        end
      end
    end
    exp_q.push_back({bv, 2'(bl), 2'(bb)});
  endtask

  // driver tasks (called one posedge + #1 after an active edge)
  task automatic send_beat(input int i, input logic [31:0] d, output int waited);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    waited = 0;
    @(negedge clk);
    while (!in_ready[i] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check_eq("accept_ready", 32'(in_ready[i]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    in_data[i]  = $urandom;
  endtask

  task automatic send_window(input int i, input int nb, input bit bubbles);
    int w, n;
    push_window(i, nb);
    for (int b = 0; b < nb; b++) begin
      send_beat(i, wb[b], w);
      if (bubbles) begin
        n = $urandom_range(0, 2);
        repeat (n) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_valid(input int i);
    int n = 0;
    @(negedge clk);
    while (!out_valid[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("out_valid_seen", 32'(out_valid[i]), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("rst_outputs", 32'(obs(0)), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare every output handshake against the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          n_out++;
          if (exp_q.size() == 0) check_eq($sformatf("unexpected_out_u%0d", i), 32'(out_valid[i]), 32'd0);
          else check_eq($sformatf("result_u%0d", i), 32'(obs(i)), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int w, n0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      out_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("por_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("por_outputs", 32'(obs(0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("por_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;

    // directed default window, with a 2-cycle latency check
    wb[0] = pk(3, 9, 2, 9); wb[1] = pk(1, 1, 1, 1);
    wb[2] = pk(9, 0, 0, 0); wb[3] = pk(5, 5, 5, 5);
    send_window(0, 4, 1'b0);
    @(negedge clk); check_eq("lat_e0", 32'(out_valid[0]), 32'd0);
    @(negedge clk); check_eq("lat_e1", 32'(out_valid[0]), 32'd0);
    @(negedge clk); check_eq("lat_e2", 32'(out_valid[0]), 32'd1);
    drain();

    // signed compare
    wb[0] = pk(8'h80, 8'hFF, 8'h01, 8'h7F); wb[1] = '0; wb[2] = '0; wb[3] = '0;
    send_window(1, 4, 1'b0);
    drain();

    // approximate compare: 0x11 and 0x13 tie, the earlier beat wins
    wb[0] = pk(8'h11, 0, 0, 0); wb[1] = pk(8'h13, 0, 0, 0);
    send_window(2, 2, 1'b0);
    drain();

    // output backpressure: hold for 10 cycles
    out_ready[0] = 1'b0;
    for (int b = 0; b < 4; b++) wb[b] = $urandom;
    send_window(0, 4, 1'b0);
    wait_valid(0);
    for (int k = 0; k < 10; k++) begin
      check_eq("hold_valid", 32'(out_valid[0]), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready[0]), 32'd0);
      check_eq("hold_value", 32'(obs(0)), 32'(exp_q[0]));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    @(negedge clk); check_eq("hs_in_ready_low", 32'(in_ready[0]), 32'd0);
    @(negedge clk); check_eq("hs_in_ready_high", 32'(in_ready[0]), 32'd1);
    check_eq("hs_valid_clear", 32'(out_valid[0]), 32'd0);
    drain();

    // reset mid-window, then a fresh window
    send_beat(0, pk(8'h7F, 8'h7E, 0, 0), w);
    send_beat(0, pk(8'hFF, 0, 0, 0), w);
    pulse_reset();
    wb[0] = pk(1, 2, 3, 4); wb[1] = pk(5, 6, 7, 8);
    wb[2] = pk(8'h10, 8'h20, 8'h1F, 0); wb[3] = pk(8'h20, 0, 0, 8'h20);
    send_window(0, 4, 1'b0);
    drain();

    // reset with a result pending: the result is discarded
    out_ready[0] = 1'b0;
    for (int b = 0; b < 4; b++) wb[b] = $urandom;
    send_window(0, 4, 1'b0);
    wait_valid(0);
    pulse_reset();
    exp_q.delete();
    out_ready[0] = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("pending_discarded", 32'(out_valid[0]), 32'd0);
    @(posedge clk);
    #1;

    // WIN=1: back-to-back beats, one result each, 3 cycles of in_ready low
    n0 = n_out;
    for (int b = 0; b < 6; b++) begin
      wb[0] = $urandom;
      push_window(3, 1);
      send_beat(3, wb[0], w);
      if (b > 0) check_eq("win1_ready_low", 32'(w), 32'd3);
    end
    drain();
    check_eq("win1_count", 32'(n_out - n0), 32'd6);

    // random windows with bubbles on the first three instances
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 4; r++) begin
        for (int b = 0; b < 4; b++) begin
          wb[b] = (r % 2 == 1) ? pk($urandom_range(0, 7), $urandom_range(0, 7),
                                    $urandom_range(0, 7), $urandom_range(0, 7))
                               : $urandom;
        end
        send_window(i, WINS[i], 1'b1);
      end
      drain();
    end

    repeat (5) @(negedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
